pwm_multi_ctrl: RTL and testbench

//   Parametrised multi-channel PWM generator; successor to the single 8-bit PWM peripheral.
//   - Adds per-channel levels, a shared clock prescaler and shadow-buffered level updates

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_channel.sv | 42 ++++
 rtl/pwm_multi_ctrl.sv | 128 ++++++++++++
 tb/tb_pwm_multi_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, helpers and types for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned MaxNch   = 16;

  // Counter terminal value: period is 2^width-1 ticks, counting 0..2^width-2.
  function automatic int unsigned pwm_max(int unsigned width);
    return (32'd1 << width) - 32'd2;
  endfunction

  typedef enum logic {
    DirUp,
    DirDown
  } pwm_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active level registers, compare and registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] level_i,
  input  logic             reload_i,
  input  logic [Width-1:0] cnt_i,
  output logic             pwm_o
);

  logic [Width-1:0] shadow_q, shadow_d;
  logic [Width-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    shadow_d = wr_en_i ? level_i : shadow_q;
    // Reload takes shadow_d so a write landing on the reload cycle wins.
    active_d = reload_i ? shadow_d : active_q;
    pwm_d    = enable_i && (cnt_i < active_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM: shared prescaler and counter, period-boundary level reload.
// Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned PRESC_W = 8,
  localparam int unsigned ChW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [WIDTH-1:0]   level_i,
  input  logic [ChW-1:0]     level_ch_i,
  input  logic               set_level_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               set_prescale_i,
  output logic [NCH-1:0]     pwm_out_o,
  output logic               period_tick_o
);

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(pwm_max(WIDTH));

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] presc_reg_q, presc_reg_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               period_tick_q, period_tick_d;
  logic               tick;
  logic               reload;

  // >= rather than == so lowering the prescale never strands presc_cnt above it.
  always_comb begin
    tick        = enable_i && (presc_cnt_q >= presc_reg_q);
    presc_cnt_d = (!enable_i || tick) ? '0 : presc_cnt_q + 1'b1;
    presc_reg_d = set_prescale_i ? prescale_i : presc_reg_q;
  end

`ifdef PWM_CENTER_ALIGNED_EN
  pwm_dir_e dir_q, dir_d;

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    reload = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (tick) begin
      if (dir_q == DirUp) begin
        if (cnt_q == CntMax) begin
          dir_d = DirDown;
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WIDTH'(1)) begin
          dir_d  = DirUp;
          reload = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q <= DirUp;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  always_comb begin
    cnt_d  = cnt_q;
    reload = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        reload = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
`endif

  assign period_tick_d = reload;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q   <= '0;
      presc_reg_q   <= '0;
      cnt_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      presc_reg_q   <= presc_reg_d;
      cnt_q         <= cnt_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign period_tick_o = period_tick_q;

  // Channel indices >= NCH match no instance, so such writes are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = set_level_i && (level_ch_i == ChW'(i));

    pwm_channel #(
      .Width (WIDTH)
    ) u_channel (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .enable_i (enable_i),
      .wr_en_i  (wr_en),
      .level_i  (level_i),
      .reload_i (reload),
      .cnt_i    (cnt_q),
      .pwm_o    (pwm_out_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl against a tick-count based reference model.
module tb_pwm_multi_ctrl;

  localparam int unsigned NCH     = 3;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned Max     = (1 << WIDTH) - 2;
`ifdef PWM_CENTER_ALIGNED_EN
  localparam int unsigned Period  = 2 * Max;
`else
  localparam int unsigned Period  = Max + 1;
`endif
  localparam int unsigned NumCyc  = 12000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [WIDTH-1:0]   level = '0;
  logic [1:0]         level_ch = '0;
  logic               set_level = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic               set_prescale = 1'b0;
  logic [NCH-1:0]     pwm_out;
  logic               period_tick;

  always #5 clk = ~clk;

  pwm_multi_ctrl #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .level_i        (level),
    .level_ch_i     (level_ch),
    .set_level_i    (set_level),
    .prescale_i     (prescale),
    .set_prescale_i (set_prescale),
    .pwm_out_o      (pwm_out),
    .period_tick_o  (period_tick)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: position in the period is (ticks since enable) mod Period.
  int unsigned    m_presc, m_preg, m_ticks;
  int unsigned    m_shadow[NCH];
  int unsigned    m_active[NCH];
  logic [NCH-1:0] exp_pwm;
  logic           exp_pt;

  task automatic model_reset();
    m_presc = 0;
    m_preg  = 0;
    m_ticks = 0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    exp_pwm = '0;
    exp_pt  = 1'b0;
  endtask

  task automatic model_step();
    bit          tick;
    int unsigned p, cnt;
    if (!enable) begin
      m_presc = 0;
      m_ticks = 0;
      exp_pwm = '0;
      exp_pt  = 1'b0;
    end else begin
      tick = (m_presc >= m_preg);
      p    = m_ticks % Period;
      cnt  = (p <= Max) ? p : Period - p;
      for (int i = 0; i < NCH; i++) exp_pwm[i] = (cnt < m_active[i]);
      exp_pt  = tick && (p == Period - 1);
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) m_ticks++;
    end
    if (set_level && (int'(level_ch) < NCH)) m_shadow[level_ch] = level;
    if (exp_pt) for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    if (set_prescale) m_preg = prescale;
  endtask

  task automatic write_level(input int unsigned ch, input int unsigned val);
    set_level = 1'b1;
    level_ch  = 2'(ch);
    level     = WIDTH'(val);
  endtask

  task automatic drive(input int cyc);
    int unsigned r;
    set_level    = 1'b0;
    set_prescale = 1'b0;
    case (cyc)
      0:    write_level(0, 64);
      1:    write_level(1, 0);
      2:    write_level(2, 255);
      3:    enable = 1'b1;
      400:  write_level(0, 128);
      1100: begin
        prescale     = 8'd3;
        set_prescale = 1'b1;
      end
      default: ;
    endcase
    if (cyc >= 4000) begin
      if (enable) begin
        if ($urandom_range(0, 1499) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 3);
        write_level($urandom_range(0, 3), (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255));
      end
      if ($urandom_range(0, 799) == 0) begin
        prescale     = PRESC_W'($urandom_range(0, 3));
        set_prescale = 1'b1;
      end
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pwm", pwm_out, '0);
    check_eq("async_rst_tick", period_tick, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_eq("reset_pwm", pwm_out, '0);
    check_eq("reset_tick", period_tick, 1'b0);
    #6 rst_n = 1'b1;
    for (int cyc = 0; cyc < NumCyc; cyc++) begin
      @(negedge clk);
      check_eq("pwm_out", pwm_out, exp_pwm);
      check_eq("period_tick", period_tick, exp_pt);
      if (cyc == 2600 || (cyc > 4000 && $urandom_range(0, 2999) == 0)) async_reset();
      drive(cyc);
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
